pcileech_tlps128_sink_arbiter: RTL and testbench
================================================

Name: pcileech_tlps128_sink_arbiter

Overview:
Packet-atomic weighted round-robin arbiter that shares the single PCIe core TX AXI-stream (128-bit) between N TLP sources: cfg-space responses, BAR responses, host FIFO TLPs and static TLPs. It replaces fixed-priority selection with configurable per-source weights, an optional strict-priority source 0, a stall watchdog and per-source packet counters. It sits directly in front of the PCIe core TX port, in the clk_pcie domain.

Parameters:
N_SRC, 4, number of requesting TLP streams (2..7)
CNT_W, 16, width of each per-source packet counter
STALL_TIMEOUT, 4096, cycles with no accepted beat mid-packet before stall_err sets

Ports:
clk_pcie  in  1  PCIe core user clock
rst_n  in  1  reset
cfg_weight  in  4*N_SRC  per-source packets per round; 0 = source disabled
cfg_strict0  in  1  1 = source 0 wins every decision it has data for
stall_clr  in  1  clears stall_err
in_tdata  in  128*N_SRC  per-source data
in_tkeepdw  in  4*N_SRC  per-source DW keep
in_tlast  in  N_SRC  per-source last beat
in_tuser  in  9*N_SRC  per-source tuser; bit0 = first beat
in_tvalid  in  N_SRC  per-source valid
in_has_data  in  N_SRC  source holds at least one complete packet
in_tready  out  N_SRC  per-source ready
out_tdata  out  128  to core
out_tkeepdw  out  4  to core
out_tlast  out  1  to core
out_tuser  out  9  to core
out_tvalid  out  1  to core
out_has_data  out  1  OR of in_has_data
out_tready  in  1  core ready
grant_id  out  3  registered grant; 0 = idle, 1..N_SRC = source index+1
stall_err  out  1  sticky watchdog flag
pkt_cnt  out  CNT_W*N_SRC  packets forwarded per source

Behaviour:
- Reset: one clock, clk_pcie; reset rst_n is asynchronous, active-low.
- On reset: grant_id=0; all credits=0; ptr=0; stall counter=0; stall_err=0; pkt_cnt=0; all out_* data/valid=0; in_tready=0.
- Datapath: out_tdata/tkeepdw/tlast/tuser/tvalid select combinationally from source grant_id-1; all are 0 when grant_id=0. There are no data registers, so the added latency is 0 cycles.
- beat = out_tvalid && out_tready. pkt_end = beat && out_tlast.
- Decision point: grant_id==0, or pkt_end. Otherwise grant_next = grant_id; a packet is never interrupted.
- in_tready[i] = out_tready && (grant_next == i+1), so a newly granted source can present data in its first cycle.
- Selection at decision point, in order:
  1. If cfg_strict0 && in_has_data[0], choose 0.
  2. Otherwise round-robin from ptr over sources with in_has_data && credit>0 && cfg_weight!=0.
  3. If none qualify but some source with cfg_weight!=0 has data: reload every credit from cfg_weight in the same cycle and search again from ptr.
  4. If still none, grant_next=0.
- Credits: on pkt_end for source i, credit[i] decrements, saturating at 0. When it reaches 0, ptr = (i+1) mod N_SRC; otherwise ptr=i. Strict-0 packets do not consume credit.
- A reload at a decision point that coincides with pkt_end applies after that decrement.
- cfg_weight changes take effect at the next reload only.
- pkt_cnt[i] increments on pkt_end from source i and wraps at 2^CNT_W.
- Stall watchdog: counts cycles where grant_id!=0 and no beat occurs. It resets on any beat or when grant_id=0. When it reaches STALL_TIMEOUT, stall_err is set and the counter saturates; the grant is kept.
- stall_err clears on stall_clr. If stall_clr and the set condition occur in the same cycle, set wins.
- Protocol errors are not detected. A granted source deasserting in_tvalid mid-packet simply holds the grant.

Test Plan:
- Single source 2, one 3-beat TLP, out_tready=1 -> grant_id 0→3 after the first decision; three beats pass unchanged; grant_id returns to 0 after tlast; pkt_cnt[2]=1.
- Weights {1,2,1,1}, all sources hold 10 packets, strict off -> forwarding order 0,1,1,2,3,0,1,1,2,3…; every packet is atomic with no source interleaving inside a packet.
- cfg_strict0=1, source 0 gains data while source 3 is mid-packet -> source 3 completes its packet, then source 0 is granted before any other source.
- cfg_weight[1]=0, only source 1 has data -> grant_id stays 0 and in_tready[1]=0 indefinitely.
- STALL_TIMEOUT=16, source 1 granted, out_tready held 0 -> stall_err=1 at the 16th idle cycle with grant unchanged; stall_clr pulse -> stall_err=0.
- Assert rst_n low mid-packet asynchronously -> grant_id=0, out_tvalid=0, pkt_cnt=0 immediately; after release, arbitration restarts at ptr=0.

Source files
------------

// File: rtl/pcileech_tlps128_sink_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_tlps128_sink_arbiter
// Purpose  : Packet-atomic weighted round-robin arbiter that shares the PCIe
//            core TX AXI-stream (128-bit) between N_SRC TLP sources, with an
//            optional strict-priority source 0, a stall watchdog and per-source
//            packet counters. Lives in the clk_pcie domain.
// Ports    : clk_pcie/rst_n      - clock, async active-low reset
//            cfg_weight          - 4-bit packets-per-round per source (0 = off)
//            cfg_strict0         - source 0 wins every decision it has data for
//            stall_clr           - clears the sticky stall_err flag
//            in_*                - per-source AXI-stream inputs, in_tready out
//            out_*               - stream to the core, out_tready in
//            grant_id            - 0 = idle, 1..N_SRC = granted source + 1
//            stall_err           - sticky watchdog flag
//            pkt_cnt             - wrapping packets forwarded per source
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_tlps128_sink_arbiter #(
    parameter int N_SRC         = 4,
    parameter int CNT_W         = 16,
    parameter int STALL_TIMEOUT = 4096
) (
    input  logic                   clk_pcie,
    input  logic                   rst_n,
    input  logic [4*N_SRC-1:0]     cfg_weight,
    input  logic                   cfg_strict0,
    input  logic                   stall_clr,
    input  logic [128*N_SRC-1:0]   in_tdata,
    input  logic [4*N_SRC-1:0]     in_tkeepdw,
    input  logic [N_SRC-1:0]       in_tlast,
    input  logic [9*N_SRC-1:0]     in_tuser,
    input  logic [N_SRC-1:0]       in_tvalid,
    input  logic [N_SRC-1:0]       in_has_data,
    output logic [N_SRC-1:0]       in_tready,
    output logic [127:0]           out_tdata,
    output logic [3:0]             out_tkeepdw,
    output logic                   out_tlast,
    output logic [8:0]             out_tuser,
    output logic                   out_tvalid,
    output logic                   out_has_data,
    input  logic                   out_tready,
    output logic [2:0]             grant_id,
    output logic                   stall_err,
    output logic [CNT_W*N_SRC-1:0] pkt_cnt
);

    localparam int c_STALL_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_STALL_W-1:0] c_STALL_MAX  = c_STALL_W'(STALL_TIMEOUT);
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(STALL_TIMEOUT - 1);

    logic [2:0]           r_grant_id;
    logic                 r_strict_pkt;   // current packet was granted by strict-0
    logic [3:0]           r_credit [N_SRC];
    logic [2:0]           r_ptr;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 r_stall_err;
    logic [CNT_W-1:0]     r_pkt_cnt [N_SRC];

    logic                 w_beat;
    logic                 w_pkt_end;
    logic                 w_decision;
    logic                 w_stall_set;
    logic [2:0]           w_grant_next;
    logic                 w_strict_next;
    logic [2:0]           w_ptr_upd;
    logic [3:0]           w_credit_dec  [N_SRC];
    logic [3:0]           w_credit_next [N_SRC];
    logic [N_SRC-1:0]     w_elig;
    logic [N_SRC-1:0]     w_want;

    // First set bit of mask at or after ptr (circularly); returns index+1, 0 if none.
    function automatic logic [2:0] rr_pick(input logic [N_SRC-1:0] mask, input logic [2:0] ptr);
        logic [2:0] w_sel;
        int         w_idx;
        w_sel = 3'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_SRC) w_idx = w_idx - N_SRC;
            if (mask[w_idx]) w_sel = 3'(w_idx + 1);
        end
        return w_sel;
    endfunction

    // Output mux straight from the granted source: no data registers.
    always_comb begin
        out_tdata   = '0;
        out_tkeepdw = '0;
        out_tlast   = 1'b0;
        out_tuser   = '0;
        out_tvalid  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant_id == 3'(i + 1)) begin
                out_tdata   = in_tdata[128*i +: 128];
                out_tkeepdw = in_tkeepdw[4*i +: 4];
                out_tlast   = in_tlast[i];
                out_tuser   = in_tuser[9*i +: 9];
                out_tvalid  = in_tvalid[i];
            end
        end
    end

    assign w_beat       = out_tvalid && out_tready;
    assign w_pkt_end    = w_beat && out_tlast;
    assign w_decision   = (r_grant_id == 3'd0) || w_pkt_end;
    assign out_has_data = |in_has_data;

    // Credit consumption at packet end; strict-0 packets leave credit and ptr alone.
    always_comb begin
        w_ptr_upd = r_ptr;
        for (int i = 0; i < N_SRC; i++) w_credit_dec[i] = r_credit[i];
        if (w_pkt_end && !r_strict_pkt) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (r_grant_id == 3'(i + 1)) begin
                    if (r_credit[i] != 4'd0) w_credit_dec[i] = r_credit[i] - 4'd1;
                    if (r_credit[i] <= 4'd1) w_ptr_upd = (i == N_SRC - 1) ? 3'd0 : 3'(i + 1);
                    else                     w_ptr_upd = 3'(i);
                end
            end
        end
    end

    // Selection. A reload refills every credit from cfg_weight; the re-search
    // then only needs has_data && weight!=0, since reloaded credit == weight.
    always_comb begin
        w_grant_next  = r_grant_id;
        w_strict_next = r_strict_pkt;
        for (int i = 0; i < N_SRC; i++) begin
            w_credit_next[i] = w_credit_dec[i];
            w_want[i] = in_has_data[i] && (cfg_weight[4*i +: 4] != 4'd0);
            w_elig[i] = w_want[i] && (w_credit_dec[i] != 4'd0);
        end
        if (w_decision) begin
            w_strict_next = 1'b0;
            if (cfg_strict0 && in_has_data[0]) begin
                w_grant_next  = 3'd1;
                w_strict_next = 1'b1;
            end else if (|w_elig) begin
                w_grant_next = rr_pick(w_elig, w_ptr_upd);
            end else begin
                w_grant_next = rr_pick(w_want, w_ptr_upd);
                if (|w_want) begin
                    for (int i = 0; i < N_SRC; i++) w_credit_next[i] = cfg_weight[4*i +: 4];
                end
            end
        end
    end

    // Ready follows the next grant so a FIFO source read-enabled now presents
    // its beat in the first granted cycle.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ready
            assign in_tready[gi] = rst_n && out_tready && (w_grant_next == 3'(gi + 1));
        end
    endgenerate

    assign w_stall_set = (r_grant_id != 3'd0) && !w_beat && (r_stall_cnt == c_STALL_LAST);

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id   <= 3'd0;
            r_strict_pkt <= 1'b0;
            r_ptr        <= 3'd0;
            r_stall_cnt  <= '0;
            r_stall_err  <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                r_credit[i]  <= 4'd0;
                r_pkt_cnt[i] <= '0;
            end
        end else begin
            r_grant_id   <= w_grant_next;
            r_strict_pkt <= w_strict_next;
            r_ptr        <= w_ptr_upd;
            for (int i = 0; i < N_SRC; i++) begin
                r_credit[i] <= w_credit_next[i];
                if (w_pkt_end && (r_grant_id == 3'(i + 1))) r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
            end
            if ((r_grant_id == 3'd0) || w_beat) r_stall_cnt <= '0;
            else if (r_stall_cnt != c_STALL_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_stall_set)    r_stall_err <= 1'b1;
            else if (stall_clr) r_stall_err <= 1'b0;
        end
    end

    assign grant_id  = r_grant_id;
    assign stall_err = r_stall_err;

    generate
        for (genvar gc = 0; gc < N_SRC; gc++) begin : g_cnt_out
            assign pkt_cnt[CNT_W*gc +: CNT_W] = r_pkt_cnt[gc];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pcileech_tlps128_sink_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcileech_tlps128_sink_arbiter
// Purpose  : Self-checking bench. Sources are modelled as read-enable FIFOs
//            (data appears the cycle after in_tready) holding queues of packets;
//            a transaction-level reference of the weighted round-robin rules
//            predicts grant, ready, output bundle, counters and stall flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcileech_tlps128_sink_arbiter;

    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int T   = 16;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
        logic [8:0]   u;
    } beat_t;

    logic              clk_pcie = 1'b0;
    logic              rst_n;
    logic [4*N-1:0]    cfg_weight;
    logic              cfg_strict0;
    logic              stall_clr;
    logic [128*N-1:0]  in_tdata;
    logic [4*N-1:0]    in_tkeepdw;
    logic [N-1:0]      in_tlast;
    logic [9*N-1:0]    in_tuser;
    logic [N-1:0]      in_tvalid;
    logic [N-1:0]      in_has_data;
    logic [N-1:0]      in_tready;
    logic [127:0]      out_tdata;
    logic [3:0]        out_tkeepdw;
    logic              out_tlast;
    logic [8:0]        out_tuser;
    logic              out_tvalid;
    logic              out_has_data;
    logic              out_tready;
    logic [2:0]        grant_id;
    logic              stall_err;
    logic [CW*N-1:0]   pkt_cnt;

    pcileech_tlps128_sink_arbiter #(.N_SRC(N), .CNT_W(CW), .STALL_TIMEOUT(T)) u_dut (
        .clk_pcie(clk_pcie), .rst_n(rst_n), .cfg_weight(cfg_weight), .cfg_strict0(cfg_strict0),
        .stall_clr(stall_clr), .in_tdata(in_tdata), .in_tkeepdw(in_tkeepdw), .in_tlast(in_tlast),
        .in_tuser(in_tuser), .in_tvalid(in_tvalid), .in_has_data(in_has_data), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeepdw(out_tkeepdw), .out_tlast(out_tlast), .out_tuser(out_tuser),
        .out_tvalid(out_tvalid), .out_has_data(out_has_data), .out_tready(out_tready),
        .grant_id(grant_id), .stall_err(stall_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk_pcie = ~clk_pcie;

    // ---------------- source models ----------------
    beat_t q [N][$];
    beat_t s_reg [N];
    logic  s_vld [N];
    int    pend  [N];   // packets whose first beat has not been read yet
    int    seq;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_tdata[128*i +: 128] = s_reg[i].d;
            in_tkeepdw[4*i +: 4]   = s_reg[i].k;
            in_tlast[i]            = s_reg[i].l;
            in_tuser[9*i +: 9]     = s_reg[i].u;
            in_tvalid[i]           = s_vld[i];
            in_has_data[i]         = (pend[i] > 0);
        end
    end

    // ---------------- reference model state ----------------
    int m_grant, m_ptr, m_stall;
    bit m_strict, m_err;
    int m_credit [N];
    int m_cnt    [N];
    int n_grant, n_ptr, n_stall;
    bit n_strict, n_err;
    int t_cr  [N];
    int n_cnt [N];
    bit e_ready [N];
    bit e_beat, e_end;

    int n_tests, n_fail;
    int dut_order [$];

    task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wt(input int i);
        return int'(cfg_weight[4*i +: 4]);
    endfunction

    function automatic int rr_next(input int p);
        for (int k = 0; k < N; k++) begin
            int s;
            s = (p + k) % N;
            if (pend[s] > 0 && t_cr[s] > 0 && wt(s) > 0) return s + 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_grant = 0; m_ptr = 0; m_stall = 0; m_strict = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin
            m_credit[i] = 0; m_cnt[i] = 0;
            q[i].delete(); s_reg[i] = '0; s_vld[i] = 1'b0; pend[i] = 0;
        end
    endtask

    task automatic model_eval();
        int g;
        bit any_want;
        g = 0; e_beat = 0; e_end = 0;
        if (m_grant != 0) begin
            g = m_grant - 1;
            e_beat = s_vld[g] && out_tready;
            e_end  = e_beat && s_reg[g].l;
        end
        for (int i = 0; i < N; i++) t_cr[i] = m_credit[i];
        n_ptr = m_ptr;
        if (e_end && !m_strict) begin
            if (t_cr[g] > 0) t_cr[g]--;
            n_ptr = (t_cr[g] == 0) ? (g + 1) % N : g;
        end
        n_grant = m_grant; n_strict = m_strict;
        if (m_grant == 0 || e_end) begin
            n_strict = 0;
            if (cfg_strict0 && pend[0] > 0) begin
                n_grant = 1; n_strict = 1;
            end else begin
                n_grant = rr_next(n_ptr);
                any_want = 0;
                for (int i = 0; i < N; i++) if (pend[i] > 0 && wt(i) > 0) any_want = 1;
                if (n_grant == 0 && any_want) begin
                    for (int i = 0; i < N; i++) t_cr[i] = wt(i);
                    n_grant = rr_next(n_ptr);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            n_cnt[i]   = m_cnt[i];
            e_ready[i] = out_tready && (n_grant == i + 1);
        end
        if (e_end) n_cnt[g] = (m_cnt[g] + 1) % (1 << CW);
        if (m_grant == 0 || e_beat) n_stall = 0;
        else if (m_stall < T)       n_stall = m_stall + 1;
        else                        n_stall = m_stall;
        n_err = m_err;
        if (m_stall == T - 1 && n_stall == T) n_err = 1;
        else if (stall_clr)                   n_err = 0;
    endtask

    task automatic model_commit();
        for (int i = 0; i < N; i++) begin
            if (e_ready[i]) begin
                if (q[i].size() > 0) begin
                    s_reg[i] = q[i].pop_front();
                    s_vld[i] = 1'b1;
                    if (s_reg[i].u[0]) pend[i]--;
                end else s_vld[i] = 1'b0;
            end else if (e_beat && m_grant == i + 1) s_vld[i] = 1'b0;
        end
        m_grant = n_grant; m_ptr = n_ptr; m_strict = n_strict;
        m_stall = n_stall; m_err = n_err;
        for (int i = 0; i < N; i++) begin
            m_credit[i] = t_cr[i]; m_cnt[i] = n_cnt[i];
        end
    endtask

    task automatic check_all();
        logic [N-1:0]    er;
        logic [CW*N-1:0] ec;
        logic [142:0]    eb;
        bit              hd;
        hd = 0;
        for (int i = 0; i < N; i++) begin
            er[i] = e_ready[i];
            ec[CW*i +: CW] = CW'(m_cnt[i]);
            if (pend[i] > 0) hd = 1;
        end
        eb = '0;
        if (m_grant != 0) eb = {s_reg[m_grant-1], s_vld[m_grant-1]};
        chk_eq("grant_id", grant_id, m_grant);
        chk_eq("in_tready", in_tready, er);
        chk_eq("out_bundle", {out_tdata, out_tkeepdw, out_tlast, out_tuser, out_tvalid}, eb);
        chk_eq("out_has_data", out_has_data, hd);
        chk_eq("stall_err", stall_err, m_err);
        chk_eq("pkt_cnt", pkt_cnt, ec);
        if (out_tvalid && out_tready && out_tlast) dut_order.push_back(int'(grant_id) - 1);
    endtask

    task automatic cycle();
        @(negedge clk_pcie);
        model_eval();
        check_all();
        @(posedge clk_pcie);
        #1;
        model_commit();
    endtask

    task automatic add_pkt(input int src, input int nb);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.d = {$urandom, $urandom, $urandom, 8'(src), 8'(k), 16'(seq)};
            b.k = 4'($urandom);
            b.l = (k == nb - 1);
            b.u = {8'($urandom), (k == 0)};
            q[src].push_back(b);
        end
        pend[src]++;
        seq++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_pcie);
        #1;
        rst_n = 1'b1;
        dut_order.delete();
    endtask

    task automatic run_until_idle(input int max);
        bit busy;
        busy = 1;
        for (int n = 0; n < max && busy; n++) begin
            busy = (m_grant != 0);
            for (int i = 0; i < N; i++) if (q[i].size() > 0 || s_vld[i] || pend[i] > 0) busy = 1;
            if (busy) cycle();
        end
        chk_eq("drain_busy", busy, 0);
    endtask

    int pat [5] = '{0, 1, 1, 2, 3};

    initial begin
        n_tests = 0; n_fail = 0; seq = 0;
        rst_n = 1'b0; cfg_weight = '0; cfg_strict0 = 1'b0; stall_clr = 1'b0; out_tready = 1'b0;
        model_reset();
        #1;
        chk_eq("rst_grant", grant_id, 0);
        chk_eq("rst_tvalid", out_tvalid, 0);
        chk_eq("rst_tready", in_tready, 0);
        chk_eq("rst_stall", stall_err, 0);
        chk_eq("rst_cnt", pkt_cnt, 0);
        do_reset();

        // single 3-beat TLP on source 2
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1}; out_tready = 1'b1;
        add_pkt(2, 3);
        run_until_idle(50);
        chk_eq("single_cnt2", pkt_cnt[CW*2 +: CW], 1);
        chk_eq("single_order_n", dut_order.size(), 1);

        // weighted round robin {1,2,1,1}, 10 packets each
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd2, 4'd1};
        for (int s = 0; s < N; s++) for (int p = 0; p < 10; p++) add_pkt(s, 1 + $urandom_range(0, 3));
        run_until_idle(1000);
        chk_eq("wrr_n", dut_order.size(), 40);
        if (dut_order.size() >= 25)
            for (int r = 0; r < 25; r++) chk_eq("wrr_order", dut_order[r], pat[r % 5]);

        // strict source 0 arrives while source 3 is mid-packet
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1}; cfg_strict0 = 1'b1;
        add_pkt(3, 4);
        for (int n = 0; n < 20 && m_grant != 4; n++) cycle();
        chk_eq("strict_g3", grant_id, 4);
        add_pkt(1, 2); add_pkt(2, 2); add_pkt(0, 2);
        run_until_idle(100);
        chk_eq("strict_n", dut_order.size(), 4);
        if (dut_order.size() == 4) begin
            chk_eq("strict_o0", dut_order[0], 3);
            chk_eq("strict_o1", dut_order[1], 0);
            chk_eq("strict_o2", dut_order[2], 1);
            chk_eq("strict_o3", dut_order[3], 2);
        end
        cfg_strict0 = 1'b0;

        // disabled source never granted
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd0, 4'd1};
        add_pkt(1, 2);
        repeat (40) cycle();
        chk_eq("w0_grant", grant_id, 0);
        chk_eq("w0_ready", in_tready[1], 0);

        // stall watchdog
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1}; out_tready = 1'b0;
        add_pkt(1, 2);
        repeat (16) cycle();
        chk_eq("stall_pre", stall_err, 0);
        cycle();
        chk_eq("stall_set", stall_err, 1);
        chk_eq("stall_grant", grant_id, 2);
        repeat (3) cycle();
        stall_clr = 1'b1;
        cycle();
        stall_clr = 1'b0;
        chk_eq("stall_clr", stall_err, 0);
        chk_eq("stall_grant2", grant_id, 2);
        out_tready = 1'b1;
        run_until_idle(50);

        // randomized traffic, weights, strict mode and backpressure
        do_reset();
        cfg_weight = {4'd2, 4'd1, 4'd3, 4'd1};
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int s;
                s = $urandom_range(0, N - 1);
                if (pend[s] < 4) add_pkt(s, 1 + $urandom_range(0, 3));
            end
            out_tready  = ((c % 500) > 480) ? 1'b0 : ($urandom_range(0, 3) != 0);
            stall_clr   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) cfg_strict0 = ~cfg_strict0;
            if ($urandom_range(0, 149) == 0)
                for (int i = 0; i < N; i++) cfg_weight[4*i +: 4] = 4'($urandom_range(0, 3));
            cycle();
        end
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1}; cfg_strict0 = 1'b0; stall_clr = 1'b0; out_tready = 1'b1;
        run_until_idle(500);

        // asynchronous reset in the middle of a packet
        do_reset();
        add_pkt(0, 4);
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_grant", grant_id, 0);
        chk_eq("arst_tvalid", out_tvalid, 0);
        chk_eq("arst_cnt", pkt_cnt, 0);
        chk_eq("arst_tready", in_tready, 0);
        do_reset();
        add_pkt(3, 1); add_pkt(2, 1);
        run_until_idle(50);
        chk_eq("arst_n", dut_order.size(), 2);
        if (dut_order.size() >= 1) chk_eq("arst_first", dut_order[0], 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
